// File: rtl/axi_pkg.sv
// Shared AXI constants, widths and beat-placement helper for the NPC simulated-memory slaves.
package axi_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;

    localparam logic [2:0] AXSIZE_1 = 3'd0;
    localparam logic [2:0] AXSIZE_2 = 3'd1;
    localparam logic [2:0] AXSIZE_4 = 3'd2;
    localparam logic [2:0] AXSIZE_8 = 3'd3;

    localparam logic [1:0] AXBURST_FIXED = 2'b00;
    localparam logic [1:0] AXBURST_INCR  = 2'b01;
    localparam logic [1:0] AXBURST_WRAP  = 2'b10;
    localparam logic [1:0] AXBURST_RSVD  = 2'b11;

    localparam logic [1:0] XRESP_OKAY   = 2'b00;
    localparam logic [1:0] XRESP_SLVERR = 2'b10;
    localparam logic [1:0] XRESP_DECERR = 2'b11;

    localparam logic [2:0] AXPORT_PRIV  = 3'b001;
    localparam logic [2:0] AXPORT_NSEC  = 3'b010;
    localparam logic [2:0] AXPORT_INSTR = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RD,
        ST_CAP,
        ST_DATA
    } rd_state_e;

    // Right-justify the addressed bytes and zero everything above the beat size.
    function automatic logic [DATA_W-1:0] place_beat(input logic [DATA_W-1:0] word,
                                                     input logic [2:0]        lane,
                                                     input logic [2:0]        size);
        logic [DATA_W-1:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (size)
            AXSIZE_1: return {56'd0, shifted[7:0]};
            AXSIZE_2: return {48'd0, shifted[15:0]};
            AXSIZE_4: return {32'd0, shifted[31:0]};
            default:  return shifted;
        endcase
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI next-beat address and WRAP window lower bound.
module axi_burst_addr
    import axi_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic [ADDR_W-1:0] wrap_lo
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        step      = ADDR_W'(1) << size;
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        wrap_lo   = addr & ~wrap_mask;
        next_addr = addr;
        case (burst)
            AXBURST_INCR: next_addr = addr + step;
            AXBURST_WRAP: next_addr = wrap_lo | ((addr + step) & wrap_mask);
            default:      next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_rd_slave.sv
// AXI read responder in front of a synchronous single-port SRAM; one transaction at a time,
// one SRAM read per beat, error class decided at accept and re-checked for range per beat.
module axi_rd_slave
    import axi_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MEM_BASE  = 64'h8000_0000,
    parameter logic [ADDR_W-1:0] MEM_BYTES = 64'h0800_0000,
    parameter int unsigned       MEM_AW    = 24,
    parameter int unsigned       LATENCY   = 0,
    parameter bit                RALIGN    = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ID_W-1:0]   ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [7:0]        ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic [2:0]        ARPORT,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              mem_ren,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] WAIT_LAST = 4'(LATENCY - 1);

    rd_state_e         state, next_state;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q, next_addr, wrap_lo_unused, offset;
    logic [7:0]        len_q, beat_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q, beat_resp;
    logic [3:0]        wait_cnt;
    logic              slverr_q, req_slverr, in_range, beat_ok;
    logic              unused_prot;

    assign unused_prot = ^(ARPORT & (AXPORT_PRIV | AXPORT_NSEC | AXPORT_INSTR));

    axi_burst_addr u_burst_addr (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr),
        .wrap_lo   (wrap_lo_unused)
    );

    always_comb begin
        req_slverr = (ARSIZE > AXSIZE_8) || (ARBURST == AXBURST_RSVD)
                  || (ARBURST == AXBURST_WRAP && !(ARLEN inside {8'd1, 8'd3, 8'd7, 8'd15}))
                  || (ARBURST != AXBURST_FIXED
                      && (ARADDR & ((ADDR_W'(1) << ARSIZE) - ADDR_W'(1))) != '0);
        // Below-base addresses wrap to a huge offset, so one compare covers both bounds.
        offset    = addr_q - MEM_BASE;
        in_range  = offset < MEM_BYTES;
        beat_ok   = !slverr_q && in_range;
        beat_resp = slverr_q ? XRESP_SLVERR : (in_range ? XRESP_OKAY : XRESP_DECERR);
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        mem_ren    = 1'b0;
        mem_addr   = '0;
        case (state)
            ST_IDLE: if (ARVALID && ARREADY) next_state = (LATENCY > 0) ? ST_WAIT : ST_RD;
            ST_WAIT: if (wait_cnt == WAIT_LAST) next_state = ST_RD;
            ST_RD: begin
                mem_ren    = beat_ok;
                mem_addr   = beat_ok ? offset[MEM_AW+2:3] : '0;
                next_state = ST_CAP;
            end
            ST_CAP:  next_state = ST_DATA;
            ST_DATA: if (RREADY) next_state = RLAST ? ST_IDLE : ST_RD;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ARREADY  <= 1'b0;
            RVALID   <= 1'b0;
            RLAST    <= 1'b0;
            RID      <= '0;
            RDATA    <= '0;
            RRESP    <= '0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
            slverr_q <= 1'b0;
            wait_cnt <= '0;
        end else begin
            ARREADY <= (next_state == ST_IDLE);
            case (state)
                ST_IDLE: if (ARVALID && ARREADY) begin
                    id_q     <= ARID;
                    addr_q   <= ARADDR;
                    len_q    <= ARLEN;
                    size_q   <= ARSIZE;
                    burst_q  <= ARBURST;
                    beat_q   <= '0;
                    slverr_q <= req_slverr;
                    wait_cnt <= '0;
                end
                ST_WAIT: wait_cnt <= wait_cnt + 4'd1;
                ST_CAP: begin
                    RVALID <= 1'b1;
                    RLAST  <= (beat_q == len_q);
                    RID    <= id_q;
                    RRESP  <= beat_resp;
                    if (!beat_ok)    RDATA <= '0;
                    else if (RALIGN) RDATA <= place_beat(mem_rdata, addr_q[2:0], size_q);
                    else             RDATA <= mem_rdata;
                end
                ST_DATA: if (RREADY) begin
                    RVALID <= 1'b0;
                    if (!RLAST) begin
                        addr_q <= next_addr;
                        beat_q <= beat_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
